// File: rtl/j4_io_uart_pkg.sv
// Shared definitions for the j4 I/O UART: register offsets, STATUS bit
// positions, engine state codes and the bit-length helper.
package j4_io_uart_pkg;

   localparam int WIDTH = 16;

   // Register offsets within the 4-word window
   localparam logic [1:0] UART_DATA   = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_DIV    = 2'd2;

   localparam logic [15:0] UART_BASE_DEFAULT = 16'h4000;

   // STATUS bit positions
   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_VALID  = 2;
   localparam int ST_RX_OVERRUN = 3;
   localparam int ST_RX_FERR   = 4;
   localparam int ST_TX_OVFL   = 5;
   localparam int ST_TX_IE     = 6;
   localparam int ST_RX_IE     = 7;

   // Serialiser / deserialiser state codes
   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   // Sticky flags and interrupt enables held by the STATUS register
   typedef struct packed {
      logic rx_ie;
      logic tx_ie;
      logic tx_overflow;
      logic rx_frame_err;
      logic rx_overrun;
   } uart_ctrl_t;

   // A divisor of zero still gives one clock per bit
   function automatic logic [15:0] bit_len(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/j4_io_fifo.sv
// Synchronous FIFO, depth 2**AW. A push while full is accepted only when a
// pop frees a slot in the same cycle; a pop while empty is ignored.
module j4_io_fifo #(
   parameter int W  = 8,
   parameter int AW = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int          DEPTH     = 1 << AW;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage array: written on an accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally; count tracks occupancy in AW+1 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/j4_io_uart.sv
// Memory-mapped UART responder on the j4 I/O bus: TX FIFO + serialiser,
// RX deserialiser + FIFO, STATUS and DIVISOR registers.
//
// Bus handshake: there is no ready; every access completes in zero wait
// states. io_in is combinational from io_ptr and is zero outside the
// window. A write (io_we) and a DATA-read pop (io_re) both take effect at
// the posedge where they are sampled, independently of each other. The
// internal FIFOs use the same rule: push/pop are one-cycle strobes that
// act at the posedge, qualified by full/empty.
module j4_io_uart
   import j4_io_uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = UART_BASE_DEFAULT,
   parameter int          FIFO_AW   = 2,
   parameter logic [15:0] DIV_RESET = 16'd868
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             io_we,
   input  logic             io_re,
   input  logic [WIDTH-1:0] io_ptr,
   input  logic [WIDTH-1:0] io_out,
   output logic [WIDTH-1:0] io_in,
   output logic             uart_tx,
   input  logic             uart_rx,
   output logic             irq
);

   // ---------------- bus decode ----------------
   logic       hit;
   logic [1:0] offset;
   logic       wr_data, rd_data, wr_status, wr_div;

   assign hit       = (io_ptr[15:2] == BASE_ADDR[15:2]);
   assign offset    = io_ptr[1:0];
   assign wr_data   = io_we & hit & (offset == UART_DATA);
   assign rd_data   = io_re & hit & (offset == UART_DATA);
   assign wr_status = io_we & hit & (offset == UART_STATUS);
   assign wr_div    = io_we & hit & (offset == UART_DIV);

   // ---------------- FIFOs ----------------
   logic       tx_full, tx_fifo_empty, tx_pop;
   logic [7:0] tx_head;
   logic       rx_full, rx_fifo_empty, rx_push;
   logic [7:0] rx_head, rx_shreg;

   j4_io_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_data),
      .din   (io_out[7:0]),
      .pop   (tx_pop),
      .full  (tx_full),
      .empty (tx_fifo_empty),
      .head  (tx_head)
   );

   j4_io_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .din   (rx_shreg),
      .pop   (rd_data),
      .full  (rx_full),
      .empty (rx_fifo_empty),
      .head  (rx_head)
   );

   // ---------------- registers ----------------
   logic [15:0] div_reg;
   uart_ctrl_t  ctrl;

   // Baud divisor, R/W at offset 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_reg <= DIV_RESET;
      else if (wr_div) div_reg <= io_out;
   end

   // ---------------- TX serialiser ----------------
   logic [1:0]  tx_state;
   logic [15:0] tx_cnt, tx_len;
   logic [2:0]  tx_bitn;
   logic [7:0]  tx_shreg;
   logic        tx_bit_end, tx_empty;

   assign tx_bit_end = (tx_cnt == tx_len - 16'd1);
   assign tx_pop     = ~tx_fifo_empty &
                       ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bit_end));
   assign tx_empty   = tx_fifo_empty & (tx_state == TX_IDLE);

   // Frame sequencer; the bit length is latched at the start of every frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_len   <= 16'd1;
         tx_bitn  <= '0;
         tx_shreg <= '0;
         uart_tx  <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_state <= TX_START;
                  tx_len   <= bit_len(div_reg);
                  tx_cnt   <= '0;
                  tx_shreg <= tx_head;
                  uart_tx  <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_state <= TX_DATA;
                  tx_cnt   <= '0;
                  tx_bitn  <= '0;
                  uart_tx  <= tx_shreg[0];
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (tx_bitn == 3'd7) begin
                     tx_state <= TX_STOP;
                     uart_tx  <= 1'b1;
                  end else begin
                     tx_bitn  <= tx_bitn + 3'd1;
                     tx_shreg <= {1'b0, tx_shreg[7:1]};
                     uart_tx  <= tx_shreg[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            default: begin // TX_STOP
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (tx_pop) begin
                     tx_state <= TX_START;
                     tx_len   <= bit_len(div_reg);
                     tx_shreg <= tx_head;
                     uart_tx  <= 1'b0;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // ---------------- RX deserialiser ----------------
   logic        rx_meta, rx_s, rx_d;
   logic [1:0]  rx_state;
   logic [15:0] rx_cnt, rx_len, rx_new_len;
   logic [2:0]  rx_bitn;
   logic        rx_fall, rx_tick, rx_stop_tick, rx_ferr_set;

   // Two-flop synchroniser plus one delay stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   assign rx_fall      = rx_d & ~rx_s;
   assign rx_tick      = (rx_cnt == 16'd0);
   assign rx_new_len   = bit_len(div_reg);
   assign rx_stop_tick = (rx_state == RX_STOP) & rx_tick;
   assign rx_push      = rx_stop_tick & rx_s;
   assign rx_ferr_set  = rx_stop_tick & ~rx_s;

   // Samples mid-bit: first at half a bit after the falling edge, then
   // once per bit. With a one-clock bit the edge cycle itself is the
   // start sample, so the engine goes straight to DATA.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_len   <= 16'd1;
         rx_bitn  <= '0;
         rx_shreg <= '0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (rx_fall) begin
                  rx_len  <= rx_new_len;
                  rx_bitn <= '0;
                  if (rx_new_len[15:1] == 15'd0) begin
                     rx_state <= RX_DATA;
                     rx_cnt   <= rx_new_len - 16'd1;
                  end else begin
                     rx_state <= RX_START;
                     rx_cnt   <= (rx_new_len >> 1) - 16'd1;
                  end
               end
            end
            RX_START: begin
               if (rx_tick) begin
                  if (rx_s) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_state <= RX_DATA;
                     rx_cnt   <= rx_len - 16'd1;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_tick) begin
                  rx_shreg <= {rx_s, rx_shreg[7:1]};
                  rx_cnt   <= rx_len - 16'd1;
                  if (rx_bitn == 3'd7) rx_state <= RX_STOP;
                  else rx_bitn <= rx_bitn + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            default: begin // RX_STOP
               if (rx_tick) rx_state <= RX_IDLE;
               else rx_cnt <= rx_cnt - 16'd1;
            end
         endcase
      end
   end

   // ---------------- status flags and irq ----------------
   logic rx_valid, tx_ovfl_set, rx_ovr_set;

   assign rx_valid    = ~rx_fifo_empty;
   assign tx_ovfl_set = wr_data & tx_full & ~tx_pop;
   assign rx_ovr_set  = rx_push & rx_full & ~rd_data;

   // Sticky flags: a new event in the same cycle as a W1C clear wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl <= '0;
      end else begin
         ctrl.rx_overrun   <= rx_ovr_set  | (ctrl.rx_overrun   & ~(wr_status & io_out[ST_RX_OVERRUN]));
         ctrl.rx_frame_err <= rx_ferr_set | (ctrl.rx_frame_err & ~(wr_status & io_out[ST_RX_FERR]));
         ctrl.tx_overflow  <= tx_ovfl_set | (ctrl.tx_overflow  & ~(wr_status & io_out[ST_TX_OVFL]));
         if (wr_status) begin
            ctrl.tx_ie <= io_out[ST_TX_IE];
            ctrl.rx_ie <= io_out[ST_RX_IE];
         end
      end
   end

   // Registered interrupt request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq <= 1'b0;
      else irq <= (rx_valid & ctrl.rx_ie) | (tx_empty & ctrl.tx_ie);
   end

   // ---------------- read mux ----------------
   logic [WIDTH-1:0] status_word;

   // Assemble STATUS from live FIFO state and the sticky flags
   always_comb begin
      status_word                = '0;
      status_word[ST_TX_FULL]    = tx_full;
      status_word[ST_TX_EMPTY]   = tx_empty;
      status_word[ST_RX_VALID]   = rx_valid;
      status_word[ST_RX_OVERRUN] = ctrl.rx_overrun;
      status_word[ST_RX_FERR]    = ctrl.rx_frame_err;
      status_word[ST_TX_OVFL]    = ctrl.tx_overflow;
      status_word[ST_TX_IE]      = ctrl.tx_ie;
      status_word[ST_RX_IE]      = ctrl.rx_ie;
   end

   // Combinational read data, zero outside the register window
   always_comb begin
      io_in = '0;
      if (hit) begin
         case (offset)
            UART_DATA:   io_in = rx_valid ? {8'h00, rx_head} : '0;
            UART_STATUS: io_in = status_word;
            UART_DIV:    io_in = div_reg;
            default:     io_in = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_j4_io_uart.sv
// Directed-plus-random bench for j4_io_uart. Expected serial frames are
// built from the frame format (start 0, 8 data bits LSB first, stop 1,
// each bit div clocks); expected received bytes come from a queue.
module tb_j4_io_uart;

   localparam logic [15:0] A_DATA = 16'h4000;
   localparam logic [15:0] A_STAT = 16'h4001;
   localparam logic [15:0] A_DIV  = 16'h4002;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        io_we = 1'b0;
   logic        io_re = 1'b0;
   logic [15:0] io_ptr = '0;
   logic [15:0] io_out = '0;
   logic [15:0] io_in;
   logic        uart_tx;
   logic        uart_rx;
   logic        irq;
   logic        loopback = 1'b0;
   logic        rx_drv = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];

   assign uart_rx = loopback ? uart_tx : rx_drv;

   j4_io_uart dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_we   (io_we),
      .io_re   (io_re),
      .io_ptr  (io_ptr),
      .io_out  (io_out),
      .io_in   (io_in),
      .uart_tx (uart_tx),
      .uart_rx (uart_rx),
      .irq     (irq)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All bus tasks are entered at a negedge and leave at the next negedge
   task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
      io_we  = 1'b1;
      io_ptr = addr;
      io_out = data;
      @(negedge clk);
      io_we  = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
      io_re  = 1'b1;
      io_ptr = addr;
      #1 data = io_in;
      @(negedge clk);
      io_re  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [159:0] exp_frame(input logic [7:0] b, input int div);
      logic [9:0]   bits;
      logic [159:0] v;
      bits = {1'b1, b, 1'b0};
      v = '0;
      for (int i = 0; i < 10 * div; i++) v[i] = bits[i / div];
      return v;
   endfunction

   // Waits (bounded) for a start bit, then records one frame clock by clock
   task automatic capture_frame(input int div, output logic [159:0] obs, output logic ok);
      obs = '0;
      ok  = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         if (uart_tx === 1'b0) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         for (int i = 0; i < 10 * div; i++) begin
            obs[i] = uart_tx;
            @(negedge clk);
         end
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = bits[i];
         repeat (div) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0]  rd;
      logic [159:0] obs;
      logic         ok;
      logic [7:0]   b, b2;
      int           div;
      logic [159:0] ovf_obs [5];
      logic         ovf_ok  [5];
      logic [7:0]   ovf_b   [6];
      logic [15:0]  st_a, st_b;

      // reset
      idle(2);
      check("reset_uart_tx", uart_tx, 1'b1);
      check("reset_irq", irq, 1'b0);
      rst_n = 1'b1;
      idle(1);
      bus_read(A_STAT, rd); check("reset_status", rd, 16'h0002);
      bus_read(A_DIV, rd);  check("reset_div", rd, 16'd868);
      bus_read(A_DATA, rd); check("reset_data_empty", rd, 16'h0000);

      // TX timing: 0x55 at div 4, then random bytes at random divisors
      for (int f = 0; f < 3; f++) begin
         div = (f == 0) ? 4 : int'($urandom_range(2, 7));
         b   = (f == 0) ? 8'h55 : 8'($urandom_range(0, 255));
         bus_write(A_DIV, 16'(div));
         fork
            capture_frame(div, obs, ok);
            begin
               bus_write(A_DATA, {8'h00, b});
               bus_read(A_STAT, rd);
            end
         join
         check("tx_busy_status", rd, 16'h0000);
         check("tx_start_seen", ok, 1'b1);
         check("tx_frame", obs, exp_frame(b, div));
         bus_read(A_STAT, rd); check("tx_empty_after", rd, 16'h0002);
      end

      // divisor written just after DATA: running frame keeps the old length
      bus_write(A_DIV, 16'd4);
      b = 8'($urandom_range(0, 255));
      fork
         capture_frame(4, obs, ok);
         begin
            bus_write(A_DATA, {8'h00, b});
            bus_write(A_DIV, 16'd6);
         end
      join
      check("div_mid_start", ok, 1'b1);
      check("div_mid_frame", obs, exp_frame(b, 4));
      b = 8'($urandom_range(0, 255));
      fork
         capture_frame(6, obs, ok);
         bus_write(A_DATA, {8'h00, b});
      join
      check("div_new_frame", obs, exp_frame(b, 6));

      // TX overflow: six back-to-back writes, the sixth is dropped
      bus_write(A_DIV, 16'd4);
      for (int i = 0; i < 6; i++) ovf_b[i] = 8'($urandom_range(0, 255));
      fork
         begin
            for (int i = 0; i < 5; i++) capture_frame(4, ovf_obs[i], ovf_ok[i]);
         end
         begin
            for (int i = 0; i < 6; i++) bus_write(A_DATA, {8'h00, ovf_b[i]});
            bus_read(A_STAT, st_a);
            bus_write(A_STAT, 16'h0020);
            bus_read(A_STAT, st_b);
         end
      join
      check("ovf_status_set", st_a, 16'h0021);
      check("ovf_status_clr", st_b, 16'h0001);
      for (int i = 0; i < 5; i++) begin
         check("ovf_frame_ok", ovf_ok[i], 1'b1);
         check("ovf_frame", ovf_obs[i], exp_frame(ovf_b[i], 4));
      end
      idle(20);
      check("ovf_line_idle", uart_tx, 1'b1);
      bus_read(A_STAT, rd); check("ovf_drained", rd, 16'h0002);

      // loopback with simultaneous DATA write and DATA read
      loopback = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'($urandom_range(0, 255)));
      foreach (exp_q[i]) bus_write(A_DATA, {8'h00, exp_q[i]});
      idle(150);
      bus_read(A_STAT, rd); check("lb_rx_valid", rd[2], 1'b1);
      bus_write(A_STAT, 16'h0080);
      idle(2);
      check("lb_irq_rx", irq, 1'b1);
      b2 = 8'($urandom_range(0, 255));
      io_we = 1'b1; io_re = 1'b1; io_ptr = A_DATA; io_out = {8'h00, b2};
      #1 rd = io_in;
      @(negedge clk);
      io_we = 1'b0; io_re = 1'b0;
      check("lb_rdwr_data", rd, {8'h00, exp_q.pop_front()});
      exp_q.push_back(b2);
      idle(60);
      while (exp_q.size() > 0) begin
         bus_read(A_DATA, rd);
         check("lb_data", rd, {8'h00, exp_q.pop_front()});
      end
      bus_read(A_DATA, rd); check("lb_empty_read", rd, 16'h0000);
      idle(2);
      check("lb_irq_clear", irq, 1'b0);
      bus_write(A_STAT, 16'h0040);
      idle(2);
      check("tx_ie_irq", irq, 1'b1);
      bus_write(A_STAT, 16'h0000);
      idle(2);
      check("ie_off_irq", irq, 1'b0);
      bus_read(A_STAT, rd); check("lb_status_end", rd, 16'h0002);
      loopback = 1'b0;

      // RX errors: frame error, glitch, overrun
      send_rx(8'($urandom_range(0, 255)), 1'b0, 4);
      idle(8);
      bus_read(A_STAT, rd); check("rx_frame_err", rd, 16'h0012);
      bus_write(A_STAT, 16'h0010);
      bus_read(A_STAT, rd); check("rx_ferr_clear", rd, 16'h0002);

      rx_drv = 1'b0;
      @(negedge clk);
      rx_drv = 1'b1;
      idle(20);
      bus_read(A_STAT, rd); check("rx_glitch", rd, 16'h0002);

      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom_range(0, 255));
         if (exp_q.size() < 4) exp_q.push_back(b);
         send_rx(b, 1'b1, 4);
         idle(3);
      end
      idle(8);
      bus_read(A_STAT, rd); check("rx_overrun_status", rd, 16'h000E);
      while (exp_q.size() > 0) begin
         bus_read(A_DATA, rd);
         check("rx_data", rd, {8'h00, exp_q.pop_front()});
      end
      bus_read(A_DATA, rd); check("rx_empty_read", rd, 16'h0000);
      bus_read(A_STAT, rd); check("rx_after_drain", rd, 16'h000A);
      bus_write(A_STAT, 16'h0008);
      bus_read(A_STAT, rd); check("rx_ovr_clear", rd, 16'h0002);

      // address decode
      bus_read(16'h4003, rd); check("dec_off3", rd, 16'h0000);
      bus_read(16'h8000, rd); check("dec_miss_data", rd, 16'h0000);
      bus_read(16'h8001, rd); check("dec_miss_stat", rd, 16'h0000);
      bus_write(16'h8002, 16'h0011);
      bus_write(16'h8000, 16'h0077);
      bus_write(16'h8001, 16'h00C0);
      idle(3);
      check("dec_miss_line", uart_tx, 1'b1);
      bus_read(A_DIV, rd);  check("dec_div_kept", rd, 16'd4);
      bus_read(A_STAT, rd); check("dec_status_kept", rd, 16'h0002);

      // reset in the middle of a frame
      bus_write(A_DATA, 16'h0000);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (uart_tx === 1'b0) ok = 1'b1;
         else @(negedge clk);
      end
      check("rst_frame_started", ok, 1'b1);
      idle(5);
      #2 rst_n = 1'b0;
      #1 check("rst_tx_high", uart_tx, 1'b1);
      check("rst_irq_low", irq, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      bus_read(A_STAT, rd); check("rst_status", rd, 16'h0002);
      bus_read(A_DIV, rd);  check("rst_div", rd, 16'd868);
      idle(50);
      check("rst_line_idle", uart_tx, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
